// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and picks the next PC each cycle.
//
// Next-PC candidates, highest priority first: exception vector, taken
// branch from EX, register jump from EX, direct jump from ID, PC+4.
// While IF is stalled, a non-exception redirect is parked in a pending
// register and applied on the edge where the stall releases.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   stall                IF stall; PC holds unless an exception occurs
//   exc_valid            exception raised this cycle
//   br_taken/br_pc4/br_imm   EX taken branch, its PC+4 and word offset
//   jr_valid/jr_addr     EX register jump and its target
//   j_valid/j_pc4_hi/j_index ID direct jump fields
//   pc                   current fetch address (registered)
//   pc_plus4             pc + 4 (combinational)
//   flush_if_id          kill the IF/ID instruction (combinational)
//   flush_id_ex          kill the ID/EX instruction (combinational)
//   redirect_pending     a redirect is parked awaiting stall release
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        exc_valid,
   input  logic        br_taken,
   input  logic [31:0] br_pc4,
   input  logic [31:0] br_imm,
   input  logic        jr_valid,
   input  logic [31:0] jr_addr,
   input  logic        j_valid,
   input  logic [3:0]  j_pc4_hi,
   input  logic [25:0] j_index,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        redirect_pending
);

   localparam int unsigned XLEN = 32;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Parkable request priorities; exceptions are never parked.
   typedef enum logic [1:0] {
      PRIO_NONE = 2'd0,
      PRIO_J    = 2'd1,
      PRIO_JR   = 2'd2,
      PRIO_BR   = 2'd3
   } prio_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   pend_target_q, pend_target_d;
   prio_t             pend_prio_q, pend_prio_d;

   logic [XLEN-1:0]   br_target;
   logic [XLEN-1:0]   j_target;
   prio_t             req_prio;
   logic [XLEN-1:0]   req_target;
   logic              req_kill_ex;
   logic              take_new;
   logic              fl_if_id;
   logic              fl_id_ex;

   // Upper offset bits fall off the left shift by two.
   logic              unused_br_imm_hi;
   assign unused_br_imm_hi = ^br_imm[31:30];

   // Target arithmetic, all modulo 2^32.
   assign br_target = br_pc4 + {br_imm[29:0], 2'b00};
   assign j_target  = {j_pc4_hi, j_index, 2'b00};
   assign pc_plus4  = pc_q + XLEN'(4);

   // Highest-priority non-exception request this cycle.
   always_comb begin
      req_prio    = PRIO_NONE;
      req_target  = '0;
      req_kill_ex = 1'b0;
      if (br_taken) begin
         req_prio    = PRIO_BR;
         req_target  = br_target;
         req_kill_ex = 1'b1;
      end else if (jr_valid) begin
         req_prio    = PRIO_JR;
         req_target  = jr_addr;
         req_kill_ex = 1'b1;
      end else if (j_valid) begin
         req_prio    = PRIO_J;
         req_target  = j_target;
         req_kill_ex = 1'b0;
      end
   end

   // A new request displaces the parked one only at equal or higher priority.
   assign take_new = (req_prio != PRIO_NONE) && (req_prio >= pend_prio_q);

   // Next-state, next-PC and flush decode.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      pend_prio_d   = pend_prio_q;
      fl_if_id      = 1'b0;
      fl_id_ex      = 1'b0;

      if (exc_valid) begin
         pc_d          = EXC_VEC;
         pend_target_d = '0;
         pend_prio_d   = PRIO_NONE;
         state_d       = RUN;
         fl_if_id      = 1'b1;
         fl_id_ex      = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (req_prio != PRIO_NONE) begin
                  fl_if_id = 1'b1;
                  fl_id_ex = req_kill_ex;
                  if (stall) begin
                     pend_target_d = req_target;
                     pend_prio_d   = req_prio;
                     state_d       = HOLD;
                  end else begin
                     pc_d = req_target;
                  end
               end else if (!stall) begin
                  pc_d = pc_plus4;
               end
            end
            HOLD: begin
               if (take_new) begin
                  fl_if_id = 1'b1;
                  fl_id_ex = req_kill_ex;
               end
               if (stall) begin
                  if (take_new) begin
                     pend_target_d = req_target;
                     pend_prio_d   = req_prio;
                  end
               end else begin
                  pc_d          = take_new ? req_target : pend_target_q;
                  pend_target_d = '0;
                  pend_prio_d   = PRIO_NONE;
                  state_d       = RUN;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // Flushes are suppressed while reset is asserted.
   assign flush_if_id = fl_if_id & ~rst;
   assign flush_id_ex = fl_id_ex & ~rst;

   // State, PC and pending registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         pend_target_q <= '0;
         pend_prio_q   <= PRIO_NONE;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
         pend_prio_q   <= pend_prio_d;
      end
   end

   assign pc               = pc_q;
   assign redirect_pending = (state_q == HOLD);

endmodule
